// File: rtl/input_control.sv
// Guess-entry front end: per-digit BCD increment while a button is held, plus a guess budget counter.
// Optional 2-flop input synchronizers on pushbuttons/confirm when INPUT_CONTROL_SYNC_EN is defined.
module input_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] display_digit_1,
  input  logic [3:0] display_digit_2,
  input  logic [3:0] display_digit_3,
  input  logic [1:0] max_digits,
  input  logic [2:0] max_guesses,
  input  logic [2:0] pushbuttons,
  input  logic       confirm,
  output logic [3:0] update_digit_1,
  output logic [3:0] update_digit_2,
  output logic [3:0] update_digit_3,
  output logic [2:0] guesses_left
);

  localparam int unsigned DigitW    = 4;
  localparam int unsigned NumDigits = 3;
  localparam int unsigned GuessW    = 3;
  localparam int unsigned SelW      = 2;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                               state_q, state_d;
  logic [GuessW-1:0]                    guesses_q, guesses_d;
  logic [NumDigits-1:0][DigitW-1:0]     upd_q, upd_d;
  logic [NumDigits-1:0][DigitW-1:0]     disp_c;
  logic [NumDigits-1:0]                 pb_s_c;
  logic                                 confirm_s_c;
  logic                                 confirm_q;
  logic                                 confirm_edge_c;

  // Illegal codes 10-15 wrap to 0 along with 9.
  function automatic logic [DigitW-1:0] inc_bcd(input logic [DigitW-1:0] d);
    return (d >= DigitW'(9)) ? DigitW'(0) : d + DigitW'(1);
  endfunction

`ifdef INPUT_CONTROL_SYNC_EN
  logic [NumDigits-1:0] pb_meta_q, pb_sync_q;
  logic                 confirm_meta_q, confirm_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pb_meta_q      <= '0;
      pb_sync_q      <= '0;
      confirm_meta_q <= 1'b0;
      confirm_sync_q <= 1'b0;
    end else begin
      pb_meta_q      <= pushbuttons;
      pb_sync_q      <= pb_meta_q;
      confirm_meta_q <= confirm;
      confirm_sync_q <= confirm_meta_q;
    end
  end

  assign pb_s_c      = pb_sync_q;
  assign confirm_s_c = confirm_sync_q;
`else
  assign pb_s_c      = pushbuttons;
  assign confirm_s_c = confirm;
`endif

  assign disp_c         = {display_digit_3, display_digit_2, display_digit_1};
  assign confirm_edge_c = confirm_s_c & ~confirm_q;

  // Next-state, budget and digit update logic.
  always_comb begin
    state_d   = state_q;
    guesses_d = guesses_q;
    upd_d     = disp_c;
    unique case (state_q)
      LOAD: begin
        guesses_d = max_guesses;
        state_d   = (max_guesses == GuessW'(0)) ? DONE : ACTIVE;
      end
      ACTIVE: begin
        if (confirm_edge_c) begin
          guesses_d = guesses_q - GuessW'(1);
          if (guesses_d == GuessW'(0)) state_d = DONE;
        end else begin
          for (int n = 0; n < int'(NumDigits); n++) begin
            if (pb_s_c[n] && (SelW'(n + 1) <= max_digits)) upd_d[n] = inc_bcd(disp_c[n]);
          end
        end
      end
      DONE: begin
        guesses_d = '0;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= LOAD;
      guesses_q <= '0;
      upd_q     <= '0;
      confirm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      guesses_q <= guesses_d;
      upd_q     <= upd_d;
      confirm_q <= confirm_s_c;
    end
  end

  assign update_digit_1 = upd_q[0];
  assign update_digit_2 = upd_q[1];
  assign update_digit_3 = upd_q[2];
  assign guesses_left   = guesses_q;

endmodule

// File: tb/tb_input_control.sv
// Directed self-checking bench for input_control; digits compared packed as {d3,d2,d1}.
module tb_input_control;

`ifdef INPUT_CONTROL_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] display_digit_1, display_digit_2, display_digit_3;
  logic [1:0] max_digits;
  logic [2:0] max_guesses;
  logic [2:0] pushbuttons;
  logic       confirm;
  logic [3:0] update_digit_1, update_digit_2, update_digit_3;
  logic [2:0] guesses_left;

  int checks   = 0;
  int failures = 0;

  input_control dut (
    .clk             (clk),
    .reset           (reset),
    .display_digit_1 (display_digit_1),
    .display_digit_2 (display_digit_2),
    .display_digit_3 (display_digit_3),
    .max_digits      (max_digits),
    .max_guesses     (max_guesses),
    .pushbuttons     (pushbuttons),
    .confirm         (confirm),
    .update_digit_1  (update_digit_1),
    .update_digit_2  (update_digit_2),
    .update_digit_3  (update_digit_3),
    .guesses_left    (guesses_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
    end
  endtask

  task automatic set_disp(input logic [11:0] d);
    {display_digit_3, display_digit_2, display_digit_1} = d;
  endtask

  function automatic logic [11:0] upd();
    return {update_digit_3, update_digit_2, update_digit_1};
  endfunction

  logic [11:0] fb_exp [4];

  initial begin
    fb_exp[0] = 12'h179;
    fb_exp[1] = 12'h180;
    fb_exp[2] = 12'h191;
    fb_exp[3] = 12'h102;

    reset = 1'b1; confirm = 1'b0; pushbuttons = 3'b000;
    max_digits = 2'd1; max_guesses = 3'd3; set_disp(12'h000);
    tick(2);
    check("reset_digits", upd(), 12'h000);
    check("reset_guesses", 12'(guesses_left), 12'h000);

    reset = 1'b0;
    tick(1);
    check("budget_load", 12'(guesses_left), 12'h003);

    // One digit: display d1=3,d2=7,d3=5.
    max_digits = 2'd1; pushbuttons = 3'b001; set_disp(12'h573);
    tick(4);
    check("one_digit_inc", upd(), 12'h574);
    set_disp(12'h229);
    tick(4);
    check("one_digit_wrap", upd(), 12'h220);
    set_disp(12'h22C);
    tick(4);
    check("illegal_wraps", upd(), 12'h220);

    // Two digits with feedback of the update into the display.
    max_digits = 2'd2; pushbuttons = 3'b011; set_disp(12'h168);
    for (int i = 0; i < 4; i++) begin
      tick(4);
      check($sformatf("feedback_%0d", i), upd(), fb_exp[i]);
      set_disp(upd());
    end

    max_digits = 2'd3; pushbuttons = 3'b111; set_disp(12'h999);
    tick(4);
    check("three_digit_wrap", upd(), 12'h000);
    max_digits = 2'd2; pushbuttons = 3'b101; set_disp(12'h123);
    tick(4);
    check("beyond_max_pass", upd(), 12'h124);
    max_digits = 2'd0; pushbuttons = 3'b111;
    tick(4);
    check("max_digits_zero", upd(), 12'h123);

    // Confirm held: one decrement, pass-through on the edge cycle only.
    max_digits = 2'd1; pushbuttons = 3'b001; set_disp(12'h555);
    tick(4);
    check("pre_confirm", upd(), 12'h556);
    confirm = 1'b1;
    tick(LAT);
    check("edge_pass", upd(), 12'h555);
    check("held_dec", 12'(guesses_left), 12'h002);
    tick(1);
    check("after_edge_inc", upd(), 12'h556);
    tick(3);
    check("held_once", 12'(guesses_left), 12'h002);
    confirm = 1'b0;
    tick(4);

    // Asynchronous reset mid-edit, then budget reload.
    #2 reset = 1'b1;
    #1;
    check("async_reset_digits", upd(), 12'h000);
    check("async_reset_guesses", 12'(guesses_left), 12'h000);
    pushbuttons = 3'b000;
    tick(1);
    #2 reset = 1'b0;
    tick(1);
    check("reload_budget", 12'(guesses_left), 12'h003);

    // Separate confirm pulses count down to DONE.
    confirm = 1'b1; tick(LAT);
    check("pulse1_latency", 12'(guesses_left), 12'h002);
    confirm = 1'b0; tick(3);
    confirm = 1'b1; tick(1); confirm = 1'b0; tick(LAT + 2);
    check("pulse2", 12'(guesses_left), 12'h001);
    confirm = 1'b1; tick(1); confirm = 1'b0; tick(LAT + 2);
    check("pulse3", 12'(guesses_left), 12'h000);
    confirm = 1'b1; tick(1); confirm = 1'b0; tick(LAT + 2);
    check("pulse4_stays0", 12'(guesses_left), 12'h000);
    max_digits = 2'd3; pushbuttons = 3'b111; set_disp(12'h321);
    tick(4);
    check("done_pass", upd(), 12'h321);

    // Zero budget goes straight to DONE.
    max_guesses = 3'd0; reset = 1'b1; tick(1); reset = 1'b0;
    tick(4);
    check("zero_budget", 12'(guesses_left), 12'h000);
    check("zero_budget_pass", upd(), 12'h321);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
